ndro_pulse_driver: RTL
======================

// Module: ndro_pulse_driver
// PURPOSE
//  Synchronous initiator for one NDRO cell: converts a valid/ready command stream (SET/RESET/READ) into
//  SFQ pulses on the cell's set/reset/clk lines, one pulse per toggle of the line, since the cell reacts to both edges.
//  Enforces the cell's critical-timing gaps and samples the cell's out toggle to return read data.
//  Sits between a test sequencer and an NDRO instance in mixed RSFQ/CMOS benches.
// PARAMETERS
//  GAP_RESET    2  cycles after a reset pulse before any further pulse (covers reset->set)
//  GAP_CLK      3  cycles after a clk pulse before any further pulse (covers clk->clk, clk->reset)
//  READ_WINDOW  8  cycles after a clk pulse to wait for an out toggle; must be >= 3
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset_n      in   1  asynchronous active-low reset
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  command accepted when cmd_valid & cmd_ready at posedge
//  cmd_op       in   2  00 NOP, 01 SET, 10 RESET, 11 READ
//  set          out  1  pulse line to cell set; each toggle = one pulse
//  reset        out  1  pulse line to cell reset; each toggle = one pulse
//  ndro_clk     out  1  pulse line to cell clk; each toggle = one pulse
//  ndro_out     in   1  cell out, asynchronous to clk; each toggle = one pulse
//  rsp_valid    out  1  read response valid, held until rsp_ready
//  rsp_ready    in   1  response consumer ready
//  rsp_data     out  1  1 = out toggle seen inside READ_WINDOW, 0 = none
//  spurious     out  1  sticky: an out toggle was seen outside a read window
// BEHAVIOUR
//  Reset (async): set/reset/ndro_clk=0, cmd_ready=0, rsp_valid=0, rsp_data=0, spurious=0, counters=0, FSM=IDLE.
//   A reset mid-operation aborts the command with no response, and may leave one transition on a pulse line.
//  FSM states: IDLE, GUARD, WAIT_RD, RESP.
//  IDLE: cmd_ready=1 iff guard counter==0. On accept:
//   NOP: no pulse; stay IDLE.
//   SET: toggle set at the next posedge (1-cycle latency); no gap is loaded; stay IDLE.
//   RESET: toggle reset at the next posedge; load guard=GAP_RESET; go to GUARD.
//   READ: toggle ndro_clk at the next posedge; load guard=GAP_CLK and win=READ_WINDOW; go to WAIT_RD.
//  GUARD: decrement guard each cycle; at 0 go to IDLE. cmd_ready=0.
//  WAIT_RD: guard and win decrement in parallel.
//   On the first synchronised out edge: rsp_data=1, go to RESP.
//   When win reaches 0 with no edge: rsp_data=0, go to RESP.
//  RESP: rsp_valid=1, stable until rsp_valid&rsp_ready.
//   Then go to GUARD if guard!=0, else to IDLE. Further out edges in RESP set spurious.
//  ndro_out passes through a 2-flop synchroniser and an edge detector (XOR with the previous level).
//   The edge detector is masked for the first 2 cycles after reset; the level sampled then is the baseline.
//  An edge outside WAIT_RD sets spurious=1, cleared only by reset.
//  Counters are $clog2(max(GAP_*,READ_WINDOW)+1) bits wide and saturate at 0; no wrap-around.
//  At most one pulse-line toggle per cycle; lines never toggle in the same cycle.
// CONFIGURATION
//  NDRO_SHADOW_CHECK_EN defined: the block keeps a shadow bit (SET->1, RESET->0, reset_n->0) and adds
//   output shadow_err (1 bit, reset 0), pulsed for one cycle with rsp_valid's rise when rsp_data!=shadow.
//  Not defined: no shadow bit; shadow_err port absent.
// STRUCTURE
//  Package ndro_drv_pkg: op_e (NOP/SET/RESET/READ encodings), state_e (IDLE/GUARD/WAIT_RD/RESP),
//   localparam SYNC_STAGES=2.
//  Sub-module ndro_edge_sync: 2-flop synchroniser + masked edge detector; outputs edge (1 cycle).
//  The top holds the FSM, counters, pulse-line toggle flops and the optional shadow logic.
// TESTING
//  1 SET, READ with a model whose out toggles 7 cycles after clk -> ndro_clk toggles once;
//    rsp_valid=1, rsp_data=1 within 10 cycles.
//  2 RESET, READ with a model that gives no toggle -> rsp_data=0 exactly READ_WINDOW+1 cycles after accept;
//    spurious stays 0.
//  3 RESET then SET back-to-back with cmd_valid held -> set toggles GAP_RESET+1 cycles after reset toggles;
//    never earlier.
//  4 Two READs back-to-back, rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable;
//    the second clk pulse is >= GAP_CLK cycles after the first, and only after the handshake.
//  5 Force an out toggle while in IDLE -> spurious=1, held until reset_n=0.
//  6 Assert reset_n=0 in WAIT_RD -> all outputs at reset values immediately, no rsp_valid afterwards.
//    With NDRO_SHADOW_CHECK_EN: SET then a READ giving no toggle -> shadow_err pulses once.

Source files
------------

// File: rtl/ndro_drv_pkg.sv
// Shared encodings and helpers for the NDRO pulse driver.
package ndro_drv_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    WAIT_RD,
    RESP
  } state_e;

  localparam int SYNC_STAGES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ndro_edge_sync.sv
// Synchronises the asynchronous cell output and flags each toggle as a 1-cycle pulse;
// latency: toggle visible on out_edge SYNC_STAGES posedges after capture; no backpressure.
module ndro_edge_sync
  import ndro_drv_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic out_edge
);

  localparam int MW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [MW-1:0]          mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      mask_q <= MW'(SYNC_STAGES);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (mask_q != '0) begin
        mask_q <= mask_q - MW'(1);
        // baseline follows the level about to reach the last stage
        prev_q <= sync_q[SYNC_STAGES-2];
      end else begin
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign out_edge = (mask_q == '0) && (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/ndro_pulse_driver.sv
// Drives SFQ pulse lines of one NDRO cell from SET/RESET/READ commands; optional NDRO_SHADOW_CHECK_EN.
// Latency: pulse 1 cycle after accept; cmd_ready low during gaps/reads; response held until rsp_ready.
module ndro_pulse_driver
  import ndro_drv_pkg::*;
#(
  parameter int GAP_RESET   = 2,
  parameter int GAP_CLK     = 3,
  parameter int READ_WINDOW = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       set,
  output logic       reset,
  output logic       ndro_clk,
  input  logic       ndro_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       spurious
`ifdef NDRO_SHADOW_CHECK_EN
  ,
  output logic       shadow_err
`endif
);

  localparam int CW = $clog2(max3(GAP_RESET, GAP_CLK, READ_WINDOW) + 1);

  state_e        state;
  logic [CW-1:0] guard_q;
  logic [CW-1:0] win_q;
  logic          out_edge;
  logic          accept;
  logic          rd_hit;
  logic          rd_miss;
  op_e           op;

  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  ndro_edge_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (ndro_out),
    .out_edge (out_edge)
  );

  assign op      = op_e'(cmd_op);
  assign accept  = cmd_valid && cmd_ready;
  assign rd_hit  = (state == WAIT_RD) && out_edge;
  assign rd_miss = (state == WAIT_RD) && !out_edge && (win_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      guard_q   <= '0;
      win_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      set       <= 1'b0;
      reset     <= 1'b0;
      ndro_clk  <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      // both counters run down freely and park at zero; loads below take priority
      guard_q <= dec_sat(guard_q);
      win_q   <= dec_sat(win_q);

      if (out_edge && state != WAIT_RD)
        spurious <= 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= (guard_q == '0);
          if (accept) begin
            case (op)
              OP_SET: set <= ~set;
              OP_RESET: begin
                reset     <= ~reset;
                guard_q   <= CW'(GAP_RESET);
                cmd_ready <= 1'b0;
                state     <= GUARD;
              end
              OP_READ: begin
                ndro_clk  <= ~ndro_clk;
                guard_q   <= CW'(GAP_CLK);
                win_q     <= CW'(READ_WINDOW);
                cmd_ready <= 1'b0;
                state     <= WAIT_RD;
              end
              default: ;
            endcase
          end
        end

        GUARD: begin
          if (guard_q < CW'(2)) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        WAIT_RD: begin
          if (rd_hit || rd_miss) begin
            rsp_data  <= rd_hit;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (guard_q > CW'(1)) begin
              state <= GUARD;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef NDRO_SHADOW_CHECK_EN
  logic shadow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= 1'b0;
      shadow_err <= 1'b0;
    end else begin
      shadow_err <= (rd_hit || rd_miss) && (rd_hit != shadow_q);
      if (accept && op == OP_SET)
        shadow_q <= 1'b1;
      else if (accept && op == OP_RESET)
        shadow_q <= 1'b0;
    end
  end
`endif

endmodule
